// File: rtl/jtag_shift_out_serializer_pkg.sv
// jtag_shift_pkg: shared FSM states and word field layout for the JTAG shift-out serializer
package jtag_shift_pkg;
  typedef enum logic [2:0] {S_IDLE, S_FETCH, S_LOAD, S_LOW, S_HIGH, S_PUSH} state_t;
  localparam int TDI_LSB = 0;
  function automatic int tms_lsb(input int bits);
    return bits;
  endfunction
endpackage

// File: rtl/jtag_shift_out_serializer_tck_gen.sv
// jtag_tck_gen: TCK half-period divider, pulses phase_done every c_TCK_DIV cycles while run
module jtag_tck_gen #(
  parameter int c_TCK_DIV = 2
) (
  input  logic rd_clk,
  input  logic rd_rst,
  input  logic run,
  output logic phase_done
);
  localparam int DW = $clog2(c_TCK_DIV + 1);
  logic [DW-1:0] r_div_cnt;
  assign phase_done = run && r_div_cnt == DW'(c_TCK_DIV - 1);
  always_ff @(posedge rd_clk)
    r_div_cnt <= (rd_rst || !run || phase_done) ? '0 : r_div_cnt + 1'b1;
endmodule

// File: rtl/jtag_shift_out_serializer.sv
// jtag_shift_out_serializer: pops TMS/TDI words, drives TCK/TMS/TDI, packs TDO into words for the shift-in FIFO
module jtag_shift_out_serializer
  import jtag_shift_pkg::*;
#(
  parameter int c_DATA_WIDTH = 32,
  parameter int c_TCK_DIV    = 2
) (
  input  logic                      rd_clk,
  input  logic                      rd_rst,
  input  logic                      enable,
  output logic                      rd_en,
  input  logic [c_DATA_WIDTH-1:0]   rd_data,
  input  logic                      rd_empty,
  output logic                      wr_en,
  output logic [c_DATA_WIDTH/2-1:0] wr_data,
  input  logic                      wr_full,
  output logic                      tck,
  output logic                      tms,
  output logic                      tdi,
  input  logic                      tdo,
  output logic                      busy
);
  localparam int c_BITS  = c_DATA_WIDTH / 2;
  localparam int BCW     = c_BITS > 1 ? $clog2(c_BITS) : 1;
  localparam int TMS_LSB = tms_lsb(c_BITS);
  state_t            r_state;
  logic [c_BITS-1:0] r_tms_word, r_tdi_word, r_cap;
  logic [BCW-1:0]    r_bit_cnt;
  logic              w_run, w_phase_done, w_fetch;
  assign w_run   = r_state == S_LOW || r_state == S_HIGH;
  assign w_fetch = enable && !rd_empty;
  jtag_tck_gen #(.c_TCK_DIV(c_TCK_DIV)) u_tck_gen (
    .rd_clk(rd_clk),
    .rd_rst(rd_rst),
    .run(w_run),
    .phase_done(w_phase_done)
  );
  always_ff @(posedge rd_clk) begin
    if (rd_rst) begin
      r_state   <= S_IDLE;
      rd_en     <= 1'b0;
      wr_en     <= 1'b0;
      wr_data   <= '0;
      tck       <= 1'b0;
      tms       <= 1'b0;
      tdi       <= 1'b0;
      busy      <= 1'b0;
      r_bit_cnt <= '0;
    end else begin
      rd_en <= 1'b0;
      wr_en <= 1'b0;
      case (r_state)
        S_IDLE: if (w_fetch) begin
          r_state <= S_FETCH;
          rd_en   <= 1'b1;
          busy    <= 1'b1;
        end
        S_FETCH: r_state <= S_LOAD;
        S_LOAD: begin
          r_tms_word <= rd_data[TMS_LSB +: c_BITS];
          r_tdi_word <= rd_data[TDI_LSB +: c_BITS];
          tms        <= rd_data[TMS_LSB];
          tdi        <= rd_data[TDI_LSB];
          r_bit_cnt  <= '0;
          r_state    <= S_LOW;
        end
        S_LOW: if (w_phase_done) begin
          tck              <= 1'b1;
          r_cap[r_bit_cnt] <= tdo;
          r_state          <= S_HIGH;
        end
        S_HIGH: if (w_phase_done) begin
          tck <= 1'b0;
          // next bit goes out on the same edge tck falls, so tms/tdi never move while tck is high
          if (r_bit_cnt == BCW'(c_BITS - 1)) r_state <= S_PUSH;
          else begin
            r_bit_cnt <= r_bit_cnt + 1'b1;
            tms       <= r_tms_word[r_bit_cnt + 1'b1];
            tdi       <= r_tdi_word[r_bit_cnt + 1'b1];
            r_state   <= S_LOW;
          end
        end
        S_PUSH: if (!wr_full) begin
          wr_en   <= 1'b1;
          wr_data <= r_cap;
          rd_en   <= w_fetch;
          busy    <= w_fetch;
          r_state <= w_fetch ? S_FETCH : S_IDLE;
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_jtag_shift_out_serializer.sv
// tb_jtag_shift_out_serializer: directed scenarios with a TDO-word scoreboard and pin-level monitors
module tb_jtag_shift_out_serializer;
  localparam int DW = 32, B = 16, DIV = 2;
  logic          rd_clk = 0, rd_rst = 1, enable = 0, wr_full = 0, inv = 0;
  logic [DW-1:0] rd_data = '0;
  logic          rd_empty, tdo, rd_en, wr_en, tck, tms, tdi, busy;
  logic [B-1:0]  wr_data;
  logic [DW-1:0] fifo_q[$];
  logic [B-1:0]  exp_q[$], got_q[$];
  int            rise_c[$], fall_c[$];
  logic          rise_tdi[$], rise_tms[$];
  int cyc = 0, rd_cnt = 0, wr_cnt = 0, bad_pop = 0, bad_chg = 0;
  int wr_cyc = -1, busy_fall_cyc = -2, last_rd_cyc = 0;
  logic p_tck = 0, p_tms = 0, p_tdi = 0, p_busy = 0;
  int passed = 0, failed = 0, total = 0;
  int rb, fb, r0, w0, bad;

  jtag_shift_out_serializer #(.c_DATA_WIDTH(DW), .c_TCK_DIV(DIV)) dut (
    .rd_clk(rd_clk), .rd_rst(rd_rst), .enable(enable), .rd_en(rd_en), .rd_data(rd_data),
    .rd_empty(rd_empty), .wr_en(wr_en), .wr_data(wr_data), .wr_full(wr_full), .tck(tck),
    .tms(tms), .tdi(tdi), .tdo(tdo), .busy(busy)
  );

  always #5 rd_clk = ~rd_clk;
  assign rd_empty = fifo_q.size() == 0;
  assign tdo = tdi ^ inv;

  always @(posedge rd_clk) begin
    cyc <= cyc + 1;
    if (rd_en) begin
      if (fifo_q.size() == 0) bad_pop <= bad_pop + 1;
      else rd_data <= fifo_q.pop_front();
    end
  end

  always @(negedge rd_clk) begin
    if (rd_en) begin rd_cnt = rd_cnt + 1; last_rd_cyc = cyc; end
    if (wr_en) begin wr_cnt = wr_cnt + 1; wr_cyc = cyc; got_q.push_back(wr_data); end
    if (tck && !p_tck) begin rise_c.push_back(cyc); rise_tdi.push_back(tdi); rise_tms.push_back(tms); end
    if (!tck && p_tck) fall_c.push_back(cyc);
    if (tck && p_tck && (tms != p_tms || tdi != p_tdi)) bad_chg = bad_chg + 1;
    if (!busy && p_busy) busy_fall_cyc = cyc;
    p_tck = tck; p_tms = tms; p_tdi = tdi; p_busy = busy;
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) passed++;
    else begin
      failed++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step(input int n);
    repeat (n) @(posedge rd_clk);
    #1;
  endtask

  function automatic int count_of(input int which);
    return which == 0 ? rise_c.size() : which == 1 ? fall_c.size() : wr_cnt;
  endfunction

  // which: 0 = tck rises, 1 = tck falls, 2 = pushes
  task automatic wait_for(input int which, input int target, input int budget, input string tag);
    int n = 0;
    while (count_of(which) < target && n < budget) begin step(1); n++; end
    chk({tag, "_wait"}, 64'(count_of(which) >= target), 64'd1);
  endtask

  function automatic logic [B-1:0] word_of(input int base, input bit use_tms);
    logic [B-1:0] w = '0;
    for (int i = 0; i < B; i++) w[i] = use_tms ? rise_tms[base + i] : rise_tdi[base + i];
    return w;
  endfunction

  task automatic drain(input string tag);
    chk({tag, "_npush"}, 64'(got_q.size()), 64'(exp_q.size()));
    while (got_q.size() > 0 && exp_q.size() > 0) chk(tag, 64'(got_q.pop_front()), 64'(exp_q.pop_front()));
    got_q.delete();
    exp_q.delete();
  endtask

  task automatic mark();
    rb = rise_c.size(); fb = fall_c.size(); r0 = rd_cnt; w0 = wr_cnt;
  endtask

  initial begin
    step(3);
    chk("reset_outputs", 64'({rd_en, wr_en, wr_data, tck, tms, tdi, busy}), 64'd0);
    rd_rst = 0;
    enable = 1;
    // empty FIFO with enable high
    mark(); bad = 0;
    for (int i = 0; i < 50; i++) begin step(1); if (rd_en || busy || tck) bad++; end
    chk("empty_idle", 64'(bad), 64'd0);
    chk("empty_no_pop", 64'(rd_cnt - r0), 64'd0);
    // single word, tdo follows tdi
    mark();
    fifo_q.push_back(32'h0001_A5A5); exp_q.push_back(16'hA5A5);
    wait_for(2, w0 + 1, 200, "w1");
    step(2);
    chk("w1_rises", 64'(rise_c.size() - rb), 64'd16);
    chk("w1_tdi_seq", 64'(word_of(rb, 0)), 64'hA5A5);
    chk("w1_tms_seq", 64'(word_of(rb, 1)), 64'h0001);
    bad = 0;
    for (int i = 1; i < 16; i++) if (rise_c[rb + i] - rise_c[rb + i - 1] != 2 * DIV) bad++;
    chk("w1_tck_period", 64'(bad), 64'd0);
    chk("w1_latency", 64'(rise_c[rb] - last_rd_cyc), 64'(2 + DIV));
    chk("w1_pops", 64'(rd_cnt - r0), 64'd1);
    chk("w1_idle", 64'({busy, tck}), 64'd0);
    drain("w1_data");
    // three words back to back, tdo inverted
    mark(); inv = 1;
    fifo_q.push_back(32'h1234_0F0F); exp_q.push_back(16'hF0F0);
    fifo_q.push_back(32'hABCD_3C3C); exp_q.push_back(16'hC3C3);
    fifo_q.push_back(32'h0000_FFFF); exp_q.push_back(16'h0000);
    wait_for(2, w0 + 3, 600, "b2b");
    step(2);
    chk("b2b_pops", 64'(rd_cnt - r0), 64'd3);
    chk("b2b_pushes", 64'(wr_cnt - w0), 64'd3);
    chk("b2b_gap1", 64'(rise_c[rb + 16] - fall_c[fb + 15]), 64'(3 + DIV));
    chk("b2b_gap2", 64'(rise_c[rb + 32] - fall_c[fb + 31]), 64'(3 + DIV));
    drain("b2b_data");
    // backpressure held in PUSH
    mark(); inv = 0; wr_full = 1;
    fifo_q.push_back(32'h0002_1E1E); exp_q.push_back(16'h1E1E);
    fifo_q.push_back(32'h0000_7777); exp_q.push_back(16'h7777);
    wait_for(1, fb + 16, 200, "full");
    bad = 0;
    for (int i = 0; i < 20; i++) begin step(1); if (wr_en || rd_en || tck) bad++; end
    chk("full_stall", 64'(bad), 64'd0);
    chk("full_no_pop", 64'(rd_cnt - r0), 64'd1);
    wr_full = 0;
    step(1);
    chk("full_release_wr_en", 64'(wr_en), 64'd1);
    wait_for(2, w0 + 2, 300, "full_done");
    step(2);
    drain("full_data");
    // reset during bit 7
    mark();
    fifo_q.push_back(32'h0000_1111);
    fifo_q.push_back(32'h0003_5A5A); exp_q.push_back(16'h5A5A);
    wait_for(0, rb + 8, 200, "rst_bit7");
    rd_rst = 1;
    step(1);
    chk("rst_outputs", 64'({rd_en, wr_en, wr_data, tck, tms, tdi, busy}), 64'd0);
    rd_rst = 0;
    rb = rise_c.size();
    wait_for(2, w0 + 1, 200, "rst_next");
    step(2);
    chk("rst_pushes", 64'(wr_cnt - w0), 64'd1);
    chk("rst_rises", 64'(rise_c.size() - rb), 64'd16);
    chk("rst_tdi_seq", 64'(word_of(rb, 0)), 64'h5A5A);
    chk("rst_tms_seq", 64'(word_of(rb, 1)), 64'h0003);
    drain("rst_data");
    // enable dropped mid-word
    mark(); inv = 1;
    fifo_q.push_back(32'h0000_C0DE); exp_q.push_back(16'h3F21);
    fifo_q.push_back(32'h0000_BEEF);
    wait_for(0, rb + 4, 200, "en_bit3");
    enable = 0;
    wait_for(2, w0 + 1, 200, "en_push");
    step(5);
    chk("en_pushes", 64'(wr_cnt - w0), 64'd1);
    chk("en_pops", 64'(rd_cnt - r0), 64'd1);
    chk("en_left_in_fifo", 64'(fifo_q.size()), 64'd1);
    chk("en_busy_fall", 64'(busy_fall_cyc), 64'(wr_cyc));
    chk("en_idle", 64'({busy, rd_en}), 64'd0);
    drain("en_data");
    exp_q.push_back(16'h4110);
    enable = 1;
    wait_for(2, w0 + 2, 200, "en_resume");
    step(2);
    drain("en_resume_data");
    chk("tms_tdi_stable_high", 64'(bad_chg), 64'd0);
    chk("no_pop_when_empty", 64'(bad_pop), 64'd0);
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
